// File: rtl/prm_chk_pkg.sv
// Shared types and defaults for the table-driven PRM edge checker.
package prm_chk_pkg;

    // Default generation: 15-bit samples, four obstacle tables, 8-bit edge counter.
    localparam int unsigned PRM_IN_W    = 15;
    localparam int unsigned PRM_NUM_TBL = 4;
    localparam int unsigned PRM_CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_e;

    // Registered edge result; field widths follow the package defaults.
    typedef struct packed {
        logic [PRM_NUM_TBL-1:0] mask;
        logic                   blocked;
        logic [PRM_CNT_W-1:0]   count;
    } result_t;

    // Saturating increment for the per-edge sample counter.
    function automatic logic [PRM_CNT_W-1:0] sat_inc(input logic [PRM_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/prm_edge_chk_engine_if.sv
// Config, sample and result channels of the PRM edge checker.
// master = sampler/graph-builder side, slave = checker engine.
interface prm_edge_chk_engine_if #(
    parameter int unsigned IN_W    = 15,
    parameter int unsigned NUM_TBL = 4,
    parameter int unsigned CNT_W   = 8
);
    localparam int unsigned TBL_W = (NUM_TBL > 1) ? $clog2(NUM_TBL) : 1;

    logic             cfg_we;
    logic [TBL_W-1:0] cfg_tbl;
    logic [IN_W-1:0]  cfg_addr;
    logic             cfg_data;
    logic             cfg_busy;

    logic             q_valid;
    logic             q_ready;
    logic [IN_W-1:0]  q_vec;
    logic             q_last;

    logic             r_valid;
    logic             r_ready;
    logic [NUM_TBL-1:0] r_mask;
    logic             r_blocked;
    logic [CNT_W-1:0] r_count;

    modport master (
        output cfg_we, cfg_tbl, cfg_addr, cfg_data,
        input  cfg_busy,
        output q_valid, q_vec, q_last,
        input  q_ready,
        input  r_valid, r_mask, r_blocked, r_count,
        output r_ready
    );

    modport slave (
        input  cfg_we, cfg_tbl, cfg_addr, cfg_data,
        output cfg_busy,
        input  q_valid, q_vec, q_last,
        output q_ready,
        output r_valid, r_mask, r_blocked, r_count,
        input  r_ready
    );

endinterface

// File: rtl/prm_tbl_ram.sv
// One obstacle truth table: 2^ADDR_W x 1 RAM, synchronous read, single write port.
// A read and write to the same entry in one cycle returns the old value.
module prm_tbl_ram #(
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic              rdata,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              wdata
);

    logic mem [0:(1 << ADDR_W)-1];

    // Contents are deliberately not reset; the table is loaded at runtime.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/prm_edge_chk_engine.sv
// Table-driven PRM edge checker: ORs per-table lookups over all samples of an edge
// and returns a per-obstacle mask, a blocked flag and a saturating sample count.
// Optional macro PRM_EDGE_STATS_EN adds edge/blocked statistics counters.
module prm_edge_chk_engine
    import prm_chk_pkg::*;
#(
    parameter int unsigned IN_W    = PRM_IN_W,
    parameter int unsigned NUM_TBL = PRM_NUM_TBL,
    parameter int unsigned CNT_W   = PRM_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    prm_edge_chk_engine_if.slave  bus
`ifdef PRM_EDGE_STATS_EN
    ,
    input  logic                  stat_clr,
    output logic [31:0]           stat_edges,
    output logic [31:0]           stat_blocked
`endif
);

    localparam int unsigned TBL_W = (NUM_TBL > 1) ? $clog2(NUM_TBL) : 1;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ACCUM = ACCUM;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [1:0] ST_HOLD  = HOLD;

    logic [1:0]         state_q, state_d;
    logic               p_vld_q, p_last_q;
    logic [NUM_TBL-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    result_t            res_q, res_d;

    logic               q_ready;
    logic               accept;
    logic               cfg_busy;
    logic [NUM_TBL-1:0] rd_data;
    logic [NUM_TBL-1:0] tbl_we;
    logic [NUM_TBL-1:0] merged;
    logic [CNT_W-1:0]   cnt_inc;

    // Forced low while reset is asserted so nothing is accepted mid-reset.
    assign q_ready  = rst_n & ((state_q == ST_IDLE) | (state_q == ST_ACCUM));
    assign accept   = bus.q_valid & q_ready;
    assign cfg_busy = (state_q != ST_IDLE) | p_vld_q;

    assign bus.q_ready   = q_ready;
    assign bus.cfg_busy  = cfg_busy;
    assign bus.r_valid   = (state_q == ST_HOLD);
    assign bus.r_mask    = res_q.mask;
    assign bus.r_blocked = res_q.blocked;
    assign bus.r_count   = res_q.count;

    for (genvar i = 0; i < NUM_TBL; i++) begin : g_tbl
        // Writes while busy are dropped so an edge never sees a half-updated table.
        assign tbl_we[i] = bus.cfg_we & ~cfg_busy & (bus.cfg_tbl == TBL_W'(i));

        prm_tbl_ram #(
            .ADDR_W (IN_W)
        ) u_tbl (
            .clk   (clk),
            .re    (accept),
            .raddr (bus.q_vec),
            .rdata (rd_data[i]),
            .we    (tbl_we[i]),
            .waddr (bus.cfg_addr),
            .wdata (bus.cfg_data)
        );
    end

    assign merged  = acc_q | rd_data;
    assign cnt_inc = sat_inc(cnt_q);

    // Next-state: FSM transitions plus accumulate/finalise of the lookup stage.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = bus.q_last ? ST_DRAIN : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept && bus.q_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (p_vld_q && p_last_q) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.r_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (p_vld_q) begin
            if (p_last_q) begin
                res_d.mask    = merged;
                res_d.blocked = |merged;
                res_d.count   = cnt_inc;
                acc_d         = '0;
                cnt_d         = '0;
            end else begin
                acc_d = merged;
                cnt_d = cnt_inc;
            end
        end
    end

    // State, lookup-stage and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            p_vld_q  <= 1'b0;
            p_last_q <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            p_vld_q  <= accept;
            p_last_q <= accept & bus.q_last;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
        end
    end

`ifdef PRM_EDGE_STATS_EN
    // Result-handshake statistics; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n || stat_clr) begin
            stat_edges   <= '0;
            stat_blocked <= '0;
        end else if (bus.r_valid && bus.r_ready) begin
            stat_edges   <= stat_edges + 32'd1;
            stat_blocked <= stat_blocked + {31'd0, res_q.blocked};
        end
    end
`endif

endmodule
